banked_dual_port_mem: RTL and testbench

Parametrised true dual-port data memory built from NUM_BANKS interleaved single-port banks, for the pipeline's load/store unit and a second requester (debug/DMA, or the second half of a misaligned access).
- Low address bits select the bank; two accesses to different banks complete in the same cycle.
- Same-bank conflicts are serialised by a grant handshake with fair alternating priority.
- Reads are registered (1-cycle latency); a saturating counter records conflicts for performance monitoring.

---
 rtl/banked_dual_port_mem.sv | 107 ++++++++++
 tb/tb_banked_dual_port_mem.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/banked_dual_port_mem.sv
// Dual-port data memory built from NUM_BANKS interleaved single-port banks.
// Same-bank conflicts are serialised by alternating priority; identical-row reads merge.
module banked_dual_port_mem #(
    parameter int DATA_W     = 32,
    parameter int NUM_BANKS  = 2,
    parameter int BANK_DEPTH = 256,
    parameter int ADDR_W     = 9,
    parameter int CNT_W      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_a,
    input  logic [ADDR_W-1:0]     i_addr_a,
    input  logic                  i_wren_a,
    input  logic [DATA_W-1:0]     i_wdata_a,
    input  logic [DATA_W/8-1:0]   i_bmask_a,
    output logic                  o_gnt_a,
    output logic                  o_rvalid_a,
    output logic [DATA_W-1:0]     o_rdata_a,
    input  logic                  i_req_b,
    input  logic [ADDR_W-1:0]     i_addr_b,
    input  logic                  i_wren_b,
    input  logic [DATA_W-1:0]     i_wdata_b,
    input  logic [DATA_W/8-1:0]   i_bmask_b,
    output logic                  o_gnt_b,
    output logic                  o_rvalid_b,
    output logic [DATA_W-1:0]     o_rdata_b,
    output logic [CNT_W-1:0]      o_conflict_cnt
);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int ROW_W  = $clog2(BANK_DEPTH);
    localparam int NBYTE  = DATA_W / 8;

    logic [DATA_W-1:0] mem_q [NUM_BANKS][BANK_DEPTH];

    logic [BANK_W-1:0] bank_a, bank_b;
    logic [ROW_W-1:0]  row_a, row_b;
    logic              same_bank, read_merge, conflict;
    logic              gnt_a, gnt_b;

    logic              prio_b_q, prio_b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;

    assign bank_a = i_addr_a[BANK_W-1:0];
    assign bank_b = i_addr_b[BANK_W-1:0];
    assign row_a  = i_addr_a[ADDR_W-1:BANK_W];
    assign row_b  = i_addr_b[ADDR_W-1:BANK_W];

    always_comb begin
        same_bank  = i_req_a && i_req_b && (bank_a == bank_b);
        read_merge = same_bank && !i_wren_a && !i_wren_b && (row_a == row_b);
        conflict   = same_bank && !read_merge;

        // On a conflict prio_b picks the winner; the loser simply holds its request.
        gnt_a = i_req_a && !(conflict && prio_b_q);
        gnt_b = i_req_b && !(conflict && !prio_b_q);

        prio_b_d = conflict ? gnt_a : prio_b_q;
        cnt_d    = (conflict && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;

        rvalid_a_d = gnt_a && !i_wren_a;
        rvalid_b_d = gnt_b && !i_wren_b;
        rdata_a_d  = rvalid_a_d ? mem_q[bank_a][row_a] : rdata_a_q;
        rdata_b_d  = rvalid_b_d ? mem_q[bank_b][row_b] : rdata_b_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prio_b_q   <= 1'b0;
            cnt_q      <= '0;
            rvalid_a_q <= 1'b0;
            rvalid_b_q <= 1'b0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
        end else begin
            prio_b_q   <= prio_b_d;
            cnt_q      <= cnt_d;
            rvalid_a_q <= rvalid_a_d;
            rvalid_b_q <= rvalid_b_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
        end
    end

    // Storage is never reset; only the write commit is suppressed while in reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int k = 0; k < NBYTE; k++) begin
                if (gnt_a && i_wren_a && i_bmask_a[k])
                    mem_q[bank_a][row_a][8*k +: 8] <= i_wdata_a[8*k +: 8];
                if (gnt_b && i_wren_b && i_bmask_b[k])
                    mem_q[bank_b][row_b][8*k +: 8] <= i_wdata_b[8*k +: 8];
            end
        end
    end

    assign o_gnt_a        = gnt_a;
    assign o_gnt_b        = gnt_b;
    assign o_rvalid_a     = rvalid_a_q;
    assign o_rvalid_b     = rvalid_b_q;
    assign o_rdata_a      = rdata_a_q;
    assign o_rdata_b      = rdata_b_q;
    assign o_conflict_cnt = cnt_q;

endmodule

// File: tb/tb_banked_dual_port_mem.sv
// Bench for banked_dual_port_mem: directed steps plus randomized traffic against a flat-memory model.
// A second instance with a 4-bit counter shares the stimulus to exercise counter saturation.
module tb_banked_dual_port_mem;
    localparam int DW  = 32;
    localparam int NB  = 2;
    localparam int BD  = 256;
    localparam int AW  = 9;
    localparam int NBY = DW / 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           req_a, wren_a, req_b, wren_b;
    logic [AW-1:0]  addr_a, addr_b;
    logic [DW-1:0]  wdata_a, wdata_b;
    logic [NBY-1:0] bm_a, bm_b;

    logic           gnt_a, gnt_b, rvalid_a, rvalid_b;
    logic [DW-1:0]  rdata_a, rdata_b;
    logic [15:0]    cnt;
    logic           gnt_a4, gnt_b4, rvalid_a4, rvalid_b4;
    logic [DW-1:0]  rdata_a4, rdata_b4;
    logic [3:0]     cnt4;

    banked_dual_port_mem #(.DATA_W(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .ADDR_W(AW), .CNT_W(16)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_req_a(req_a), .i_addr_a(addr_a), .i_wren_a(wren_a), .i_wdata_a(wdata_a), .i_bmask_a(bm_a),
        .o_gnt_a(gnt_a), .o_rvalid_a(rvalid_a), .o_rdata_a(rdata_a),
        .i_req_b(req_b), .i_addr_b(addr_b), .i_wren_b(wren_b), .i_wdata_b(wdata_b), .i_bmask_b(bm_b),
        .o_gnt_b(gnt_b), .o_rvalid_b(rvalid_b), .o_rdata_b(rdata_b),
        .o_conflict_cnt(cnt)
    );

    banked_dual_port_mem #(.DATA_W(DW), .NUM_BANKS(NB), .BANK_DEPTH(BD), .ADDR_W(AW), .CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset(rst),
        .i_req_a(req_a), .i_addr_a(addr_a), .i_wren_a(wren_a), .i_wdata_a(wdata_a), .i_bmask_a(bm_a),
        .o_gnt_a(gnt_a4), .o_rvalid_a(rvalid_a4), .o_rdata_a(rdata_a4),
        .i_req_b(req_b), .i_addr_b(addr_b), .i_wren_b(wren_b), .i_wdata_b(wdata_b), .i_bmask_b(bm_b),
        .o_gnt_b(gnt_b4), .o_rvalid_b(rvalid_b4), .o_rdata_b(rdata_b4),
        .o_conflict_cnt(cnt4)
    );

    // Reference model: one flat word array indexed by the full address.
    logic [DW-1:0] mdl_mem [NB*BD];
    bit            prio_m = 1'b0;
    int            cnt_m = 0, cnt4_m = 0;
    bit            rv_a_m = 1'b0, rv_b_m = 1'b0;
    logic [DW-1:0] rd_a_m = '0, rd_b_m = '0;
    bit            ga_m, gb_m, conf_m;
    int            passed = 0, total = 0;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_a(bit r, bit w, int a, logic [DW-1:0] d, logic [NBY-1:0] m);
        req_a = r; wren_a = w; addr_a = AW'(a); wdata_a = d; bm_a = m;
    endtask

    task automatic set_b(bit r, bit w, int a, logic [DW-1:0] d, logic [NBY-1:0] m);
        req_b = r; wren_b = w; addr_b = AW'(a); wdata_b = d; bm_b = m;
    endtask

    // One clock: check grants mid-cycle, advance the model, check registered outputs after the edge.
    task automatic step(string tag);
        bit same, merge;
        same   = req_a && req_b && ((int'(addr_a) % NB) == (int'(addr_b) % NB));
        merge  = same && !wren_a && !wren_b && (addr_a == addr_b);
        conf_m = same && !merge;
        ga_m   = conf_m ? !prio_m : req_a;
        gb_m   = conf_m ?  prio_m : req_b;

        @(negedge clk);
        chk({tag, ".gnt_a"},  gnt_a,  ga_m);
        chk({tag, ".gnt_b"},  gnt_b,  gb_m);
        chk({tag, ".gnt_a4"}, gnt_a4, ga_m);
        chk({tag, ".gnt_b4"}, gnt_b4, gb_m);

        if (rst) begin
            rv_a_m = 0; rv_b_m = 0; rd_a_m = '0; rd_b_m = '0;
            cnt_m = 0; cnt4_m = 0; prio_m = 0;
        end else begin
            rv_a_m = ga_m && !wren_a;
            rv_b_m = gb_m && !wren_b;
            if (rv_a_m) rd_a_m = mdl_mem[addr_a];
            if (rv_b_m) rd_b_m = mdl_mem[addr_b];
            for (int k = 0; k < NBY; k++) begin
                if (ga_m && wren_a && bm_a[k]) mdl_mem[addr_a][8*k +: 8] = wdata_a[8*k +: 8];
                if (gb_m && wren_b && bm_b[k]) mdl_mem[addr_b][8*k +: 8] = wdata_b[8*k +: 8];
            end
            if (conf_m) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt4_m < 15) cnt4_m++;
                prio_m = ga_m;
            end
        end

        @(posedge clk);
        #1;
        chk({tag, ".rvalid_a"},  rvalid_a,  rv_a_m);
        chk({tag, ".rvalid_b"},  rvalid_b,  rv_b_m);
        chk({tag, ".rdata_a"},   rdata_a,   rd_a_m);
        chk({tag, ".rdata_b"},   rdata_b,   rd_b_m);
        chk({tag, ".cnt"},       cnt,       cnt_m);
        chk({tag, ".cnt4"},      cnt4,      cnt4_m);
        chk({tag, ".rvalid_a4"}, rvalid_a4, rv_a_m);
        chk({tag, ".rvalid_b4"}, rvalid_b4, rv_b_m);
        chk({tag, ".rdata_a4"},  rdata_a4,  rd_a_m);
        chk({tag, ".rdata_b4"},  rdata_b4,  rd_b_m);
    endtask

    initial begin
        for (int i = 0; i < NB*BD; i++) mdl_mem[i] = '0;
        rst = 1'b1;
        set_a(0, 0, 0, '0, '0);
        set_b(0, 0, 0, '0, '0);
        #1;
        step("reset0");
        step("reset1");
        chk("reset.cnt", cnt, 0);
        rst = 1'b0;

        // Give every location a known value before any reads.
        for (int i = 0; i < BD; i++) begin
            set_a(1, 1, 2*i,     $urandom, 4'hF);
            set_b(1, 1, 2*i + 1, $urandom, 4'hF);
            step("fill");
        end
        set_b(0, 0, 0, '0, '0);

        // Different banks complete together.
        set_a(1, 1, 4, 32'hDEADBEEF, 4'hF);
        set_b(1, 1, 5, 32'h12345678, 4'hF);
        step("t1.wr");
        set_a(1, 0, 5, '0, '0);
        set_b(1, 0, 4, '0, '0);
        step("t1.rd");
        chk("t1.rdata_a", rdata_a, 32'h12345678);
        chk("t1.rdata_b", rdata_b, 32'hDEADBEEF);
        chk("t1.cnt", cnt, 0);

        // Byte-masked write.
        set_b(0, 0, 0, '0, '0);
        set_a(1, 1, 4, 32'h000000AA, 4'h1);
        step("t2.wr");
        set_a(1, 0, 4, '0, '0);
        step("t2.rd");
        chk("t2.rdata_a", rdata_a, 32'hDEADBEAA);

        // Same-bank conflict with alternating priority.
        set_a(1, 0, 2, '0, '0);
        set_b(1, 1, 6, 32'h55AA55AA, 4'hF);
        step("t3.c0");
        chk("t3.cnt1", cnt, 1);
        set_a(1, 0, 0, '0, '0);
        step("t3.c1");
        chk("t3.cnt2", cnt, 2);
        set_b(0, 0, 0, '0, '0);
        step("t3.c2");

        // Read merge: same row, both reads.
        set_a(1, 0, 8, '0, '0);
        set_b(1, 0, 8, '0, '0);
        step("t4.merge");
        chk("t4.cnt", cnt, 2);

        // Twenty conflicting cycles saturate the 4-bit counter.
        set_a(1, 1, 0, 32'h0BADF00D, 4'hF);
        set_b(1, 1, 2, 32'hCAFEF00D, 4'hF);
        for (int i = 0; i < 20; i++) step("t5.sat");
        chk("t5.cnt4_sat", cnt4, 15);
        chk("t5.cnt", cnt, 22);

        // Leave prio_b set, then reset while a read is granted.
        step("t6.prio_set");
        set_a(1, 0, 5, '0, '0);
        set_b(0, 0, 0, '0, '0);
        rst = 1'b1;
        step("t6.reset_read");
        chk("t6.rvalid_dropped", rvalid_a, 0);
        chk("t6.cnt_cleared", cnt, 0);
        rst = 1'b0;
        set_a(1, 1, 0, 32'h11111111, 4'hF);
        set_b(1, 1, 2, 32'h22222222, 4'hF);
        step("t6.prio_cleared");
        set_a(1, 0, 5, '0, '0);
        set_b(0, 0, 0, '0, '0);
        step("t6.mem_kept");
        chk("t6.rdata_a", rdata_a, 32'h12345678);

        // Random traffic on a small address window; denied requests are held.
        for (int i = 0; i < 400; i++) begin
            if (!(req_a && !ga_m))
                set_a($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                      $urandom, NBY'($urandom));
            if (!(req_b && !gb_m))
                set_b($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15),
                      $urandom, NBY'($urandom));
            rst = ($urandom_range(0, 49) == 0);
            step("rand");
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
